bot_state_sync: RTL
===================

// Module: bot_state_sync
// PURPOSE
//  Synthesizable N-bot state synchroniser for the multi-bot co-ordination datapath.
//  Each bot channel delivers one (x, y, vx, vy) sample per round over a valid/ready handshake.
//  The block gathers one sample from every bot and publishes all bots together as one snapshot.
//  If a round does not complete within a timeout, it publishes a partial snapshot with a freshness mask.
//  Sits between the per-bot sensor/comm front-ends and the collision/trajectory logic.
// PARAMETERS
//  N_BOTS   3     number of bot channels (1..16)
//  W        16    sample width, signed fixed point, FRAC fractional bits
//  FRAC     11    fractional bits (informational; no arithmetic on samples)
//  TMO_CYC  1024  cycles from first capture of a round to forced publish (>=2)
//  RND_W    16    width of round counter
// PORTS
//  clk        in   1         single clock, rising edge
//  rst        in   1         synchronous, active-high reset
//  in_valid   in   N_BOTS    per-bot sample valid
//  in_ready   out  N_BOTS    per-bot sample accepted when valid&ready
//  in_x       in   N_BOTS*W  bot i at [i*W +: W]; same packing for in_y, in_vx, in_vy
//  in_y       in   N_BOTS*W
//  in_vx      in   N_BOTS*W
//  in_vy      in   N_BOTS*W
//  snap_valid out  1         snapshot available; held until snap_ready
//  snap_ready in   1         consumer accepts snapshot when snap_valid&snap_ready
//  snap_x     out  N_BOTS*W  published state; same packing for snap_y, snap_vx, snap_vy
//  snap_y     out  N_BOTS*W
//  snap_vx    out  N_BOTS*W
//  snap_vy    out  N_BOTS*W
//  snap_fresh out  N_BOTS    bit i=1: bot i captured in this snapshot's round
//  snap_round out  RND_W     round number of the snapshot; wraps modulo 2^RND_W
//  tmo_pulse  out  1         one-cycle pulse when a partial snapshot is published
// BEHAVIOUR
//  Reset values:
//   - all snap_* = 0, snap_valid = 0, tmo_pulse = 0
//   - capture registers = 0, captured flags = 0, round = 0, timer = 0, state = IDLE
//   - in_ready = 0 during the reset cycle
//  Capture:
//   - in_ready[i] = !captured[i] && state != HOLD
//   - On a handshake, capture regs[i] take the inputs and captured[i] is set.
//   - A bot gets at most one capture per round; further valids stall.
//  FSM:
//   - IDLE: no captures yet. Any capture -> COLLECT with timer = 1.
//   - COLLECT: timer increments every cycle. Round ends when all flags are set, or timer == TMO_CYC.
//   - Publish at round end, if snap_valid == 0 or snap_ready == 1 that cycle:
//     - snap regs <= capture regs (registered, 1 cycle after the completing capture)
//     - snap_fresh <= flags; snap_round <= round; round++
//     - flags and timer cleared; go to IDLE
//     - tmo_pulse = 1 only if the round ended on timeout with a flag missing
//   - HOLD: entered when a round ends but the snapshot buffer is occupied. All in_ready = 0 and the timer is frozen. Publish on the first cycle snap_ready is 1, then go to IDLE.
//  Missing bots:
//   - Capture regs of uncaptured bots keep the previous round's values.
//   - Those stale values are published with fresh = 0.
//  Simultaneous events:
//   - The last capture and timer == TMO_CYC in the same cycle count as complete: no tmo_pulse.
//   - Publish and consumer accept in the same cycle are allowed (back-to-back snapshots).
//   - Captures for the next round are accepted in the cycle after publish.
//  Reset mid-round or in HOLD discards all partial data and any pending snapshot.
//  Samples pass through bit-exact; no scaling or saturation.
// STRUCTURE
//  Shared package bot_sync_pkg:
//   - state enum (IDLE, COLLECT, HOLD)
//   - defaults for W/FRAC
//   - function to pack/unpack a lane [i*W +: W]
//  One sub-module bot_capture_lane, instantiated per bot with a generate loop:
//   - holds x/y/vx/vy capture regs and the captured flag
//   - drives in_ready from a global 'open' and a 'clear' input
//  The top holds the FSM, timer, round counter and snapshot registers.
// TESTING
//  1. N=3. Bots 1, 0, 2 send x=0x0800 (1.0) etc. on cycles 5, 8, 9.
//     -> snap_valid at cycle 10, fresh=3'b111, round=0, tmo_pulse=0.
//  2. TMO_CYC=16. Only bots 0 and 2 send in round 1.
//     -> publish 16 cycles after the first capture, fresh=3'b101, tmo_pulse=1.
//     -> snap_x[1] still holds bot 1's round-0 value.
//  3. Hold snap_ready=0 and complete a second round.
//     -> state HOLD, in_ready=000, timer frozen.
//     -> Raise snap_ready: snapshot 2 appears the next cycle with round=1.
//  4. Bot 0 asserts valid for 4 cycles.
//     -> only the first sample is captured; in_ready[0]=0 until publish, then it takes the next value.
//  5. Assert rst while in COLLECT with 2 bots captured.
//     -> all flags clear, round=0, snap_valid=0; the next full round publishes round=0.
//  6. Last capture lands on the timer==TMO_CYC cycle.
//     -> fresh=111, tmo_pulse=0. Run 2^RND_W rounds (RND_W=4): snap_round wraps 15->0.

Source files
------------

// File: rtl/bot_state_sync_pkg.sv
// bot_sync_pkg: shared state enum, width defaults and lane packing helper for bot_state_sync
package bot_sync_pkg;
  localparam int W_DEF = 16;
  localparam int FRAC_DEF = 11;
  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;
  function automatic int lane_lo(input int i, input int w);
    return i * w;
  endfunction
endpackage

// File: rtl/bot_state_sync_if.sv
// bot_state_sync_if: per-bot sample handshake and snapshot bus (master = front-ends/consumer, slave = synchroniser)
interface bot_state_sync_if #(
  parameter int N_BOTS = 3,
  parameter int W = 16,
  parameter int RND_W = 16
);
  logic [N_BOTS-1:0] in_valid;
  logic [N_BOTS-1:0] in_ready;
  logic [N_BOTS*W-1:0] in_x;
  logic [N_BOTS*W-1:0] in_y;
  logic [N_BOTS*W-1:0] in_vx;
  logic [N_BOTS*W-1:0] in_vy;
  logic snap_valid;
  logic snap_ready;
  logic [N_BOTS*W-1:0] snap_x;
  logic [N_BOTS*W-1:0] snap_y;
  logic [N_BOTS*W-1:0] snap_vx;
  logic [N_BOTS*W-1:0] snap_vy;
  logic [N_BOTS-1:0] snap_fresh;
  logic [RND_W-1:0] snap_round;
  logic tmo_pulse;
  modport master (
    output in_valid, in_x, in_y, in_vx, in_vy, snap_ready,
    input in_ready, snap_valid, snap_x, snap_y, snap_vx, snap_vy, snap_fresh, snap_round, tmo_pulse
  );
  modport slave (
    input in_valid, in_x, in_y, in_vx, in_vy, snap_ready,
    output in_ready, snap_valid, snap_x, snap_y, snap_vx, snap_vy, snap_fresh, snap_round, tmo_pulse
  );
endinterface

// File: rtl/bot_state_sync_lane.sv
// bot_capture_lane: one bot's capture regs and captured flag (ports: clk, rst, open, clear, valid, x/y/vx/vy in, ready, fire, captured, x_n/y_n/vx_n/vy_n next-values)
module bot_capture_lane #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         open,
  input  logic         clear,
  input  logic         valid,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] vx,
  input  logic [W-1:0] vy,
  output logic         ready,
  output logic         fire,
  output logic         captured,
  output logic [W-1:0] x_n,
  output logic [W-1:0] y_n,
  output logic [W-1:0] vx_n,
  output logic [W-1:0] vy_n
);
  logic [W-1:0] x_q, y_q, vx_q, vy_q;
  assign ready = open && !captured;
  assign fire = valid && ready;
  assign x_n = fire ? x : x_q;
  assign y_n = fire ? y : y_q;
  assign vx_n = fire ? vx : vx_q;
  assign vy_n = fire ? vy : vy_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
      vx_q <= '0;
      vy_q <= '0;
      captured <= 1'b0;
    end else begin
      x_q <= x_n;
      y_q <= y_n;
      vx_q <= vx_n;
      vy_q <= vy_n;
      captured <= !clear && (captured || fire);
    end
  end
endmodule

// File: rtl/bot_state_sync.sv
// bot_state_sync: gathers one sample per bot per round and publishes full or timed-out partial snapshots (ports: clk, rst, bus slave)
module bot_state_sync
  import bot_sync_pkg::*;
#(
  parameter int N_BOTS = 3,
  parameter int W = W_DEF,
  parameter int FRAC = FRAC_DEF,
  parameter int TMO_CYC = 1024,
  parameter int RND_W = 16
) (
  input logic clk,
  input logic rst,
  bot_state_sync_if.slave bus
);
  localparam int TW = $clog2(TMO_CYC + 1);
  localparam logic [TW-1:0] TMO = TW'(TMO_CYC);
  if (FRAC >= W) begin : g_bad_frac
    $error("FRAC must be smaller than W");
  end
  state_t state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [RND_W-1:0] round;
  logic [N_BOTS-1:0] captured, fire, flags_n;
  logic [N_BOTS*W-1:0] cx, cy, cvx, cvy;
  logic open, all_n, round_end, publish, start;
  assign open = !rst && state != HOLD;
  for (genvar i = 0; i < N_BOTS; i++) begin : g_lane
    bot_capture_lane #(.W(W)) u_lane (
      .clk(clk),
      .rst(rst),
      .open(open),
      .clear(publish),
      .valid(bus.in_valid[i]),
      .x(bus.in_x[lane_lo(i, W) +: W]),
      .y(bus.in_y[lane_lo(i, W) +: W]),
      .vx(bus.in_vx[lane_lo(i, W) +: W]),
      .vy(bus.in_vy[lane_lo(i, W) +: W]),
      .ready(bus.in_ready[i]),
      .fire(fire[i]),
      .captured(captured[i]),
      .x_n(cx[lane_lo(i, W) +: W]),
      .y_n(cy[lane_lo(i, W) +: W]),
      .vx_n(cvx[lane_lo(i, W) +: W]),
      .vy_n(cvy[lane_lo(i, W) +: W])
    );
  end
  // Round end looks at this cycle's captures too, so the snapshot follows the completing capture by one cycle.
  always_comb begin
    flags_n = captured | fire;
    all_n = &flags_n;
    start = state == IDLE && |fire;
    round_end = state != HOLD && (all_n || (state == COLLECT && timer == TMO));
    publish = state == HOLD ? bus.snap_ready : round_end && (!bus.snap_valid || bus.snap_ready);
    state_n = publish ? IDLE : round_end ? HOLD : start ? COLLECT : state;
    timer_n = publish ? '0 : start ? TW'(1) : (state == COLLECT && !round_end) ? timer + 1'b1 : timer;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
      round <= '0;
      bus.snap_valid <= 1'b0;
      bus.snap_x <= '0;
      bus.snap_y <= '0;
      bus.snap_vx <= '0;
      bus.snap_vy <= '0;
      bus.snap_fresh <= '0;
      bus.snap_round <= '0;
      bus.tmo_pulse <= 1'b0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      bus.tmo_pulse <= publish && !all_n;
      if (publish) begin
        bus.snap_x <= cx;
        bus.snap_y <= cy;
        bus.snap_vx <= cvx;
        bus.snap_vy <= cvy;
        bus.snap_fresh <= flags_n;
        bus.snap_round <= round;
        round <= round + 1'b1;
        bus.snap_valid <= 1'b1;
      end else if (bus.snap_ready) begin
        bus.snap_valid <= 1'b0;
      end
    end
  end
endmodule
